bus_mem_responder: RTL and testbench
====================================

Name: bus_mem_responder

Overview:
- Memory-side end of the CPU's multiplexed 8-bit bus. It decodes address and data phases driven by the CPU and serves a ROM (instruction/constant store) and a small RAM.
- Returns read data on the CPU's `data_in` lane.
- Holds a latched address with post-access auto-increment, so sequential fetches need one address phase followed by repeated data phases.
- Sits between the CPU core and the memory arrays at the top level. It also exposes a ROM programming port for testbench and boot loading.

Parameters:
- DATA_BITS, 8, width of bus lanes and memory words.
- ADDR_BITS, 8, width of latched address; ROM depth is 2**ADDR_BITS.
- RAM_ADDR_BITS, 4, RAM index width; RAM depth is 2**RAM_ADDR_BITS (16).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high.
- bus_in  input  DATA_BITS  CPU `data_out` lane; carries an address or write data.
- bus_valid  input  1  qualifies the current cycle as a bus phase.
- addr_data  input  1  1 = address phase, 0 = data phase.
- rom_ram  input  1  space select, sampled at address phase only: 0 = ROM, 1 = RAM.
- bus_we  input  1  data phase direction: 1 = write, 0 = read.
- bus_out  output  DATA_BITS  read data to CPU `data_in`; registered.
- rdy  output  1  one-cycle pulse: data phase completed.
- err  output  1  one-cycle pulse: illegal access.
- prog_we  input  1  ROM program write enable.
- prog_addr  input  ADDR_BITS  ROM program address.
- prog_data  input  DATA_BITS  ROM program data.

Behaviour:
- Reset is synchronous and active-high on clk.
  - Reset values: state = IDLE, addr = 0, space = ROM, bus_out = 0, rdy = 0, err = 0.
  - Memory arrays are not cleared.
  - Reset mid-burst returns to IDLE; the next data phase needs a fresh address phase.
- States are IDLE (no address held) and ARMED (address held).
- Address phase (bus_valid=1, addr_data=1), from any state:
  - addr <= bus_in[ADDR_BITS-1:0]; space <= rom_ram; state -> ARMED.
  - No rdy or err; bus_out holds its value.
- Data phase in ARMED (bus_valid=1, addr_data=0):
  - Read: bus_out <= ROM[addr], or RAM[addr[RAM_ADDR_BITS-1:0]] when space = RAM.
    - Data and rdy are visible in the cycle after the phase (1-cycle latency).
  - Write, space = RAM: RAM[addr low bits] <= bus_in; rdy pulses the next cycle; bus_out unchanged.
  - Write, space = ROM: no write; err pulses the next cycle, rdy stays 0.
  - After every data phase (including the ROM-write error): addr <= addr + 1, wrapping 2**ADDR_BITS-1 -> 0. State stays ARMED.
- Data phase in IDLE: ignored; err pulses the next cycle; bus_out, addr and state unchanged.
- Out-of-range RAM addresses: RAM accesses use only the low RAM_ADDR_BITS of addr, so addr 0x13 aliases RAM[3].
- Back-to-back data phases: one per cycle; rdy stays high continuously; each read returns the next sequential word.
- bus_valid=0: no state change; rdy = 0 and err = 0 the next cycle; bus_out holds.
- Programming port:
  - prog_we=1 writes ROM[prog_addr] <= prog_data; it is legal in any state and independent of the bus.
  - Same-cycle prog_we and bus read of the same ROM address: the read returns the old word; the new word is visible from the next read.
  - prog_we during reset is still honoured.
- rdy and err are never both 1 in the same cycle.

Test Plan:
- Reset, then program ROM[0x10..0x12] = 0xA1, 0xB2, 0xC3. Drive address phase 0x10 with rom_ram=0, then three read data phases -> bus_out = 0xA1, 0xB2, 0xC3 on the cycles after each phase, with rdy high for 3 consecutive cycles.
- Address phase 0x05 with rom_ram=1, write 0x5A, then address phase 0x05, read -> bus_out = 0x5A with rdy. Address phase 0x15, read -> 0x5A (alias).
- Address phase 0xFF ROM, two reads with ROM[0xFF]=0x11 and ROM[0x00]=0x22 -> 0x11 then 0x22 (address wrap).
- After reset, a read data phase with no address phase -> err pulse, rdy = 0, bus_out = 0x00. Then address phase 0x00 ROM and a write of 0x33 -> err pulse, ROM[0x00] unchanged on read-back.
- Address phase to ROM, one read, assert reset for 1 cycle, then a data phase -> err pulse (state IDLE). Checks: bus_out = 0 after reset, rdy = 0.
- Same cycle: prog_we to ROM[0x20]=0x77 (old 0x66) and a read of 0x20 -> bus_out = 0x66. Re-address 0x20 and read -> 0x77.

Source files
------------

// File: rtl/bus_mem_responder.sv
// Memory-side responder for the CPU's multiplexed 8-bit bus: latches an address, then serves
// sequential ROM/RAM data phases with post-access auto-increment. ROM is loaded via a program port.
module bus_mem_responder #(
  parameter int unsigned DATA_BITS     = 8,
  parameter int unsigned ADDR_BITS     = 8,
  parameter int unsigned RAM_ADDR_BITS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] bus_in,
  input  logic                 bus_valid,
  input  logic                 addr_data,
  input  logic                 rom_ram,
  input  logic                 bus_we,
  output logic [DATA_BITS-1:0] bus_out,
  output logic                 rdy,
  output logic                 err,
  input  logic                 prog_we,
  input  logic [ADDR_BITS-1:0] prog_addr,
  input  logic [DATA_BITS-1:0] prog_data
);

  localparam int unsigned RomDepth = 2 ** ADDR_BITS;
  localparam int unsigned RamDepth = 2 ** RAM_ADDR_BITS;

  typedef enum logic {
    StIdle,
    StArmed
  } state_e;

  logic [DATA_BITS-1:0] rom_mem [RomDepth];
  logic [DATA_BITS-1:0] ram_mem [RamDepth];

  state_e                 state_q, state_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic                   space_q, space_d;
  logic [DATA_BITS-1:0]   bus_out_q, bus_out_d;
  logic                   rdy_q, rdy_d;
  logic                   err_q, err_d;
  logic                   ram_we;
  logic [RAM_ADDR_BITS-1:0] ram_idx;
  logic [DATA_BITS-1:0]   rd_word;

  // RAM ignores the upper address bits, so higher addresses alias onto it.
  assign ram_idx = addr_q[RAM_ADDR_BITS-1:0];
  assign rd_word = space_q ? ram_mem[ram_idx] : rom_mem[addr_q];

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    space_d   = space_q;
    bus_out_d = bus_out_q;
    rdy_d     = 1'b0;
    err_d     = 1'b0;
    ram_we    = 1'b0;

    if (bus_valid) begin
      if (addr_data) begin
        addr_d  = bus_in[ADDR_BITS-1:0];
        space_d = rom_ram;
        state_d = StArmed;
      end else begin
        unique case (state_q)
          StIdle: begin
            err_d = 1'b1;
          end
          StArmed: begin
            if (!bus_we) begin
              bus_out_d = rd_word;
              rdy_d     = 1'b1;
            end else if (space_q) begin
              ram_we = 1'b1;
              rdy_d  = 1'b1;
            end else begin
              err_d = 1'b1;
            end
            // Increment even on a rejected ROM write so the burst stays in step.
            addr_d = addr_q + ADDR_BITS'(1);
          end
          default: begin
            state_d = StIdle;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      space_q   <= 1'b0;
      bus_out_q <= '0;
      rdy_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      space_q   <= space_d;
      bus_out_q <= bus_out_d;
      rdy_q     <= rdy_d;
      err_q     <= err_d;
    end
  end

  // Program port is independent of reset and the bus; a same-cycle read sees the old word.
  always_ff @(posedge clk) begin
    if (prog_we) begin
      rom_mem[prog_addr] <= prog_data;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we && !reset) begin
      ram_mem[ram_idx] <= bus_in;
    end
  end

  assign bus_out = bus_out_q;
  assign rdy     = rdy_q;
  assign err     = err_q;

endmodule

// File: tb/tb_bus_mem_responder.sv
// Self-checking bench for bus_mem_responder: directed scenarios plus randomized traffic
// compared against an array-based behavioural model.
module tb_bus_mem_responder;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] bus_in;
  logic       bus_valid;
  logic       addr_data;
  logic       rom_ram;
  logic       bus_we;
  logic [7:0] bus_out;
  logic       rdy;
  logic       err;
  logic       prog_we;
  logic [7:0] prog_addr;
  logic [7:0] prog_data;

  int vectors     = 0;
  int miscompares = 0;

  // Behavioural model state
  logic [7:0] m_rom [256];
  logic [7:0] m_ram [16];
  bit         m_armed;
  int         m_addr;
  bit         m_space;
  logic [7:0] e_out;
  bit         e_rdy;
  bit         e_err;

  always #5 clk = ~clk;

  bus_mem_responder #(
    .DATA_BITS    (8),
    .ADDR_BITS    (8),
    .RAM_ADDR_BITS(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus_in   (bus_in),
    .bus_valid(bus_valid),
    .addr_data(addr_data),
    .rom_ram  (rom_ram),
    .bus_we   (bus_we),
    .bus_out  (bus_out),
    .rdy      (rdy),
    .err      (err),
    .prog_we  (prog_we),
    .prog_addr(prog_addr),
    .prog_data(prog_data)
  );

  task automatic drive(input bit v, input bit ad, input bit rr, input bit we,
                       input logic [7:0] din);
    bus_valid = v;
    addr_data = ad;
    rom_ram   = rr;
    bus_we    = we;
    bus_in    = din;
  endtask

  task automatic model_step();
    logic [7:0] rd;
    rd = m_space ? m_ram[m_addr % 16] : m_rom[m_addr];
    if (reset) begin
      m_armed = 0; m_addr = 0; m_space = 0;
      e_out = 8'h00; e_rdy = 0; e_err = 0;
    end else begin
      e_rdy = 0;
      e_err = 0;
      if (bus_valid && addr_data) begin
        m_addr  = int'(bus_in);
        m_space = rom_ram;
        m_armed = 1;
      end else if (bus_valid) begin
        if (!m_armed) begin
          e_err = 1;
        end else begin
          if (!bus_we) begin
            e_out = rd;
            e_rdy = 1;
          end else if (m_space) begin
            m_ram[m_addr % 16] = bus_in;
            e_rdy = 1;
          end else begin
            e_err = 1;
          end
          m_addr = (m_addr + 1) % 256;
        end
      end
    end
    if (prog_we) m_rom[prog_addr] = prog_data;
  endtask

  // Applies the current inputs for one clock and advances the model alongside.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic prog(input logic [7:0] a, input logic [7:0] d);
    drive(0, 0, 0, 0, 8'h00);
    prog_we = 1; prog_addr = a; prog_data = d;
    tick();
    prog_we = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    drive(0, 0, 0, 0, 8'h00);
    tick();
    vectors++;
    if ({bus_out, rdy, err} !== {8'h00, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset: got out=%h rdy=%b err=%b, want out=00 rdy=0 err=0", bus_out, rdy, err);
    end
    reset = 0;
  endtask

  task automatic test_ram_fill();
    drive(1, 1, 1, 0, 8'h00);
    tick();
    for (int i = 0; i < 16; i++) begin
      drive(1, 0, 1, 1, 8'($urandom));
      tick();
      vectors++;
      if ({rdy, err} !== 2'b10) begin
        miscompares++;
        $display("FAIL ram_fill[%0d]: got rdy=%b err=%b, want rdy=1 err=0", i, rdy, err);
      end
    end
  endtask

  task automatic test_rom_burst();
    logic [7:0] exp [3];
    exp = '{8'hA1, 8'hB2, 8'hC3};
    prog(8'h10, 8'hA1);
    prog(8'h11, 8'hB2);
    prog(8'h12, 8'hC3);
    drive(1, 1, 0, 0, 8'h10);
    tick();
    vectors++;
    if ({bus_out, rdy, err} !== {e_out, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL rom_addr_phase: got out=%h rdy=%b err=%b, want out=%h rdy=0 err=0",
               bus_out, rdy, err, e_out);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 8'h00);
      tick();
      vectors++;
      if ({bus_out, rdy, err} !== {exp[i], 1'b1, 1'b0}) begin
        miscompares++;
        $display("FAIL rom_burst[%0d]: got out=%h rdy=%b err=%b, want out=%h rdy=1 err=0",
                 i, bus_out, rdy, err, exp[i]);
      end
    end
    drive(0, 0, 0, 0, 8'h00);
    tick();
    vectors++;
    if ({bus_out, rdy, err} !== {8'hC3, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL rom_burst_idle: got out=%h rdy=%b err=%b, want out=c3 rdy=0 err=0",
               bus_out, rdy, err);
    end
  endtask

  task automatic test_ram_alias();
    logic [7:0] held;
    held = e_out;
    drive(1, 1, 1, 0, 8'h05);
    tick();
    drive(1, 0, 1, 1, 8'h5A);
    tick();
    vectors++;
    if ({bus_out, rdy, err} !== {held, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL ram_write: got out=%h rdy=%b err=%b, want out=%h rdy=1 err=0",
               bus_out, rdy, err, held);
    end
    drive(1, 1, 1, 0, 8'h05);
    tick();
    drive(1, 0, 1, 0, 8'h00);
    tick();
    vectors++;
    if ({bus_out, rdy, err} !== {8'h5A, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL ram_read: got out=%h rdy=%b err=%b, want out=5a rdy=1 err=0",
               bus_out, rdy, err);
    end
    drive(1, 1, 1, 0, 8'h15);
    tick();
    drive(1, 0, 1, 0, 8'h00);
    tick();
    vectors++;
    if ({bus_out, rdy, err} !== {8'h5A, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL ram_alias: got out=%h rdy=%b err=%b, want out=5a rdy=1 err=0",
               bus_out, rdy, err);
    end
  endtask

  task automatic test_addr_wrap();
    prog(8'hFF, 8'h11);
    prog(8'h00, 8'h22);
    drive(1, 1, 0, 0, 8'hFF);
    tick();
    drive(1, 0, 0, 0, 8'h00);
    tick();
    vectors++;
    if ({bus_out, rdy, err} !== {8'h11, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL wrap_ff: got out=%h rdy=%b err=%b, want out=11 rdy=1 err=0",
               bus_out, rdy, err);
    end
    tick();
    vectors++;
    if ({bus_out, rdy, err} !== {8'h22, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL wrap_00: got out=%h rdy=%b err=%b, want out=22 rdy=1 err=0",
               bus_out, rdy, err);
    end
  endtask

  task automatic test_illegal();
    reset = 1;
    drive(0, 0, 0, 0, 8'h00);
    tick();
    reset = 0;
    drive(1, 0, 0, 0, 8'h00);
    tick();
    vectors++;
    if ({bus_out, rdy, err} !== {8'h00, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL idle_data_phase: got out=%h rdy=%b err=%b, want out=00 rdy=0 err=1",
               bus_out, rdy, err);
    end
    drive(1, 1, 0, 0, 8'h00);
    tick();
    drive(1, 0, 0, 1, 8'h33);
    tick();
    vectors++;
    if ({bus_out, rdy, err} !== {8'h00, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL rom_write: got out=%h rdy=%b err=%b, want out=00 rdy=0 err=1",
               bus_out, rdy, err);
    end
    drive(1, 1, 0, 0, 8'h00);
    tick();
    drive(1, 0, 0, 0, 8'h00);
    tick();
    vectors++;
    if ({bus_out, rdy, err} !== {8'h22, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL rom_write_readback: got out=%h rdy=%b err=%b, want out=22 rdy=1 err=0",
               bus_out, rdy, err);
    end
  endtask

  task automatic test_reset_mid_burst();
    drive(1, 1, 0, 0, 8'h10);
    tick();
    drive(1, 0, 0, 0, 8'h00);
    tick();
    vectors++;
    if ({bus_out, rdy, err} !== {8'hA1, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL pre_reset_read: got out=%h rdy=%b err=%b, want out=a1 rdy=1 err=0",
               bus_out, rdy, err);
    end
    reset = 1;
    drive(0, 0, 0, 0, 8'h00);
    tick();
    reset = 0;
    vectors++;
    if ({bus_out, rdy, err} !== {8'h00, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL mid_reset: got out=%h rdy=%b err=%b, want out=00 rdy=0 err=0",
               bus_out, rdy, err);
    end
    drive(1, 0, 0, 0, 8'h00);
    tick();
    vectors++;
    if ({bus_out, rdy, err} !== {8'h00, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL post_reset_data: got out=%h rdy=%b err=%b, want out=00 rdy=0 err=1",
               bus_out, rdy, err);
    end
  endtask

  task automatic test_prog_collision();
    prog(8'h20, 8'h66);
    drive(1, 1, 0, 0, 8'h20);
    tick();
    drive(1, 0, 0, 0, 8'h00);
    prog_we = 1; prog_addr = 8'h20; prog_data = 8'h77;
    tick();
    prog_we = 0;
    vectors++;
    if ({bus_out, rdy, err} !== {8'h66, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL collision_old: got out=%h rdy=%b err=%b, want out=66 rdy=1 err=0",
               bus_out, rdy, err);
    end
    drive(1, 1, 0, 0, 8'h20);
    tick();
    drive(1, 0, 0, 0, 8'h00);
    tick();
    vectors++;
    if ({bus_out, rdy, err} !== {8'h77, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL collision_new: got out=%h rdy=%b err=%b, want out=77 rdy=1 err=0",
               bus_out, rdy, err);
    end
  endtask

  task automatic test_random(input int n);
    for (int i = 0; i < n; i++) begin
      reset = ($urandom_range(0, 49) == 0);
      drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0), 1'($urandom),
            1'($urandom), 8'($urandom));
      prog_we   = ($urandom_range(0, 7) == 0);
      prog_addr = 8'($urandom);
      prog_data = 8'($urandom);
      tick();
      vectors++;
      if ({bus_out, rdy, err} !== {e_out, e_rdy, e_err}) begin
        miscompares++;
        $display("FAIL random[%0d]: got out=%h rdy=%b err=%b, want out=%h rdy=%b err=%b",
                 i, bus_out, rdy, err, e_out, e_rdy, e_err);
      end
      vectors++;
      if ((rdy && err) !== 1'b0) begin
        miscompares++;
        $display("FAIL rdy_err_exclusive[%0d]: got rdy=%b err=%b, want not both 1", i, rdy, err);
      end
    end
    reset   = 0;
    prog_we = 0;
  endtask

  initial begin
    reset = 1;
    prog_we = 0; prog_addr = 8'h00; prog_data = 8'h00;
    drive(0, 0, 0, 0, 8'h00);
    // Load the whole ROM while reset is held; writes must land regardless.
    for (int i = 0; i < 256; i++) begin
      prog_we   = 1;
      prog_addr = 8'(i);
      prog_data = 8'($urandom);
      tick();
    end
    prog_we = 0;

    test_reset();
    test_ram_fill();
    test_rom_burst();
    test_ram_alias();
    test_addr_wrap();
    test_illegal();
    test_reset_mid_burst();
    test_prog_collision();
    test_random(800);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
